// File: rtl/temp_scan_ctrl_pkg.sv
// Shared constants and types for the temperature scan controller.
// State encoding and result widths used by controller and bench.
package temp_mon_pkg;

  localparam int N_SENSORS = 5;
  localparam int DATA_W    = 8;
  localparam int SUM_W     = 16;
  localparam int CNT_W     = 8;
  localparam int IDX_W     = $clog2(N_SENSORS);
  localparam int LEFT_W    = $clog2(SUM_W) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DIV  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/temp_scan_ctrl_if.sv
// Result bus from the scan controller to the display/alarm logic.
// Valid/ready handshake carrying sum, count, average and no-sensor.
interface temp_scan_ctrl_if;
  import temp_mon_pkg::*;

  logic [SUM_W-1:0]  temp_sum;
  logic [CNT_W-1:0]  nr_active_sensors;
  logic [DATA_W-1:0] temp_avg;
  logic              no_sensor;
  logic              avg_valid;
  logic              avg_ready;

  modport master (
    output temp_sum,
    output nr_active_sensors,
    output temp_avg,
    output no_sensor,
    output avg_valid,
    input  avg_ready
  );

  modport slave (
    input  temp_sum,
    input  nr_active_sensors,
    input  temp_avg,
    input  no_sensor,
    input  avg_valid,
    output avg_ready
  );

endinterface

// File: rtl/temp_scan_ctrl_divider.sv
// Restoring divider, one quotient bit per cycle, SUM_W cycles total.
// The first bit is produced on the start edge; done pulses with the last.
import temp_mon_pkg::*;

module seq_divider (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SUM_W-1:0]  dividend,
  input  logic [CNT_W-1:0]  divisor,
  output logic [DATA_W-1:0] quotient,
  output logic              done
);

  logic [CNT_W-1:0]  rem_q;
  logic [CNT_W-1:0]  dvsr_q;
  logic [SUM_W-1:0]  quo_q;
  logic [LEFT_W-1:0] left_q;
  logic              run_q;
  logic              done_q;

  // One restoring step: shift in next dividend bit, subtract if it fits.
  // Remainder stays below divisor, so CNT_W bits plus one carry suffice.
  function automatic logic [CNT_W+SUM_W-1:0] div_step(
    input logic [CNT_W-1:0] r,
    input logic [SUM_W-1:0] q,
    input logic [CNT_W-1:0] d
  );
    logic [CNT_W:0] t;
    logic           ge;
    t  = {r, q[SUM_W-1]};
    ge = (t >= {1'b0, d});
    if (ge) t = t - {1'b0, d};
    return {t[CNT_W-1:0], q[SUM_W-2:0], ge};
  endfunction

  // Iteration registers: load and first step on start, then run down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      dvsr_q <= '0;
      quo_q  <= '0;
      left_q <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        {rem_q, quo_q} <= div_step('0, dividend, divisor);
        dvsr_q <= divisor;
        left_q <= LEFT_W'(SUM_W - 1);
        run_q  <= 1'b1;
      end else if (run_q) begin
        {rem_q, quo_q} <= div_step(rem_q, quo_q, dvsr_q);
        left_q <= left_q - LEFT_W'(1);
        if (left_q == LEFT_W'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q[DATA_W-1:0];
  assign done     = done_q;

endmodule

// File: rtl/temp_scan_ctrl.sv
// Temperature scan sequencer: trigger, snapshot, accumulate, divide.
// Presents sum/count/average on a valid/ready result bus.
import temp_mon_pkg::*;

module temp_scan_ctrl #(
  parameter int PERIOD = 1000
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        start_i,
  input  logic                        auto_en_i,
  input  logic [N_SENSORS*DATA_W-1:0] sensors_data_i,
  input  logic [N_SENSORS-1:0]        sensors_en_i,
  output logic                        busy_o,
  output logic                        overrun_o,
  temp_scan_ctrl_if.master            res
);

  localparam int TMR_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  state_t state_q, state_d;

  logic [TMR_W-1:0]            timer_q;
  logic                        tick;
  logic                        trig;
  logic                        pending_q;
  logic                        overrun_q;
  logic [N_SENSORS*DATA_W-1:0] data_snap_q;
  logic [N_SENSORS-1:0]        en_snap_q;
  logic [SUM_W-1:0]            acc_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [IDX_W-1:0]            idx_q;
  logic [DATA_W-1:0]           cur_data;
  logic                        div_first_q;
  logic                        div_start;
  logic [DATA_W-1:0]           div_quo;
  logic                        div_done;
  logic                        capture;
  logic                        load_res;
  logic                        handshake;

  logic [SUM_W-1:0]  sum_q;
  logic [CNT_W-1:0]  nr_q;
  logic [DATA_W-1:0] avg_q;
  logic              ns_q;
  logic              valid_q;

  assign tick      = auto_en_i && (timer_q == TMR_W'(PERIOD - 1));
  assign trig      = start_i | tick;
  assign cur_data  = data_snap_q[idx_q*DATA_W +: DATA_W];
  assign handshake = valid_q && res.avg_ready;

  // Free-running period timer, held at zero while auto mode is off.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      timer_q <= '0;
    end else if (!auto_en_i || tick) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TMR_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state and per-cycle strobes.
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    div_start = 1'b0;
    load_res  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (trig || pending_q) begin
          capture = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (idx_q == IDX_W'(N_SENSORS - 1)) state_d = ST_DIV;
      end
      ST_DIV: begin
        if (div_first_q) begin
          if (cnt_q == '0) begin
            load_res = 1'b1;
            state_d  = ST_OUT;
          end else begin
            div_start = 1'b1;
          end
        end else if (div_done) begin
          load_res = 1'b1;
          state_d  = ST_OUT;
        end
      end
      ST_OUT: begin
        if (handshake) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One-deep trigger queue; a trigger on a full queue is reported.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        pending_q <= 1'b0;
      end else if (trig) begin
        if (pending_q) overrun_q <= 1'b1;
        else           pending_q <= 1'b1;
      end
    end
  end

  // Snapshot on capture, then sum one sensor per SCAN cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_snap_q <= '0;
      en_snap_q   <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      div_first_q <= 1'b0;
    end else begin
      div_first_q <= (state_q == ST_SCAN) && (state_d == ST_DIV);
      if (capture) begin
        data_snap_q <= sensors_data_i;
        en_snap_q   <= sensors_en_i;
        acc_q       <= '0;
        cnt_q       <= '0;
        idx_q       <= '0;
      end else if (state_q == ST_SCAN) begin
        if (en_snap_q[idx_q]) begin
          acc_q <= acc_q + SUM_W'(cur_data);
          cnt_q <= cnt_q + CNT_W'(1);
        end
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  seq_divider u_div (
    .clk      (clk_i),
    .rst_n    (rst_n_i),
    .start    (div_start),
    .dividend (acc_q),
    .divisor  (cnt_q),
    .quotient (div_quo),
    .done     (div_done)
  );

  // Result registers: loaded on OUT entry, held until the next one.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sum_q   <= '0;
      nr_q    <= '0;
      avg_q   <= '0;
      ns_q    <= 1'b0;
      valid_q <= 1'b0;
    end else if (load_res) begin
      sum_q   <= acc_q;
      nr_q    <= cnt_q;
      avg_q   <= (cnt_q == '0) ? '0 : div_quo;
      ns_q    <= (cnt_q == '0);
      valid_q <= 1'b1;
    end else if (handshake) begin
      valid_q <= 1'b0;
    end
  end

  assign res.temp_sum          = sum_q;
  assign res.nr_active_sensors = nr_q;
  assign res.temp_avg          = avg_q;
  assign res.no_sensor         = ns_q;
  assign res.avg_valid         = valid_q;
  assign busy_o                = (state_q != ST_IDLE);
  assign overrun_o             = overrun_q;

endmodule

// File: tb/tb_temp_scan_ctrl.sv
// Directed bench for temp_scan_ctrl: vector table plus
// hold/pending, periodic-trigger overrun and async-reset sequences.
module tb_temp_scan_ctrl;
  import temp_mon_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        auto_en;
  logic [39:0] data;
  logic [4:0]  en;
  logic        busy;
  logic        ovr;

  temp_scan_ctrl_if rif ();

  temp_scan_ctrl #(.PERIOD(20)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .start_i        (start),
    .auto_en_i      (auto_en),
    .sensors_data_i (data),
    .sensors_en_i   (en),
    .busy_o         (busy),
    .overrun_o      (ovr),
    .res            (rif.master)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int hs_cnt = 0;
  int ovr_cnt = 0;

  always @(negedge clk) begin
    if (rif.avg_valid && rif.avg_ready) hs_cnt++;
    if (ovr) ovr_cnt++;
  end

  typedef struct {
    logic [4:0]  en;
    logic [39:0] data;
    int          sum;
    int          cnt;
    int          avg;
    int          ns;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [39:0] pack5(input int s4, input int s3,
                                        input int s2, input int s1,
                                        input int s0);
    return {8'(s4), 8'(s3), 8'(s2), 8'(s1), 8'(s0)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!rif.avg_valid && lat < 40);
  endtask

  task automatic chk_res(input string tag, input int s, input int c,
                         input int a, input int n);
    chk({tag, " sum"}, int'(rif.temp_sum), s);
    chk({tag, " cnt"}, int'(rif.nr_active_sensors), c);
    chk({tag, " avg"}, int'(rif.temp_avg), a);
    chk({tag, " no_sensor"}, int'(rif.no_sensor), n);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    en    = v.en;
    data  = v.data;
    start = 1'b1;
    step();
    start = 1'b0;
    en    = ~v.en;
    data  = ~v.data;
    lat   = 0;
    do begin
      step();
      lat++;
      if (lat == 1) chk({tag, " busy@1"}, int'(busy), 1);
    end while (!rif.avg_valid && lat < 40);
    chk({tag, " latency"}, lat, v.lat);
    chk_res(tag, v.sum, v.cnt, v.avg, v.ns);
    step();
    chk({tag, " valid drop"}, int'(rif.avg_valid), 0);
    chk({tag, " idle"}, int'(busy), 0);
  endtask

  initial begin
    int lat;
    int s0;
    int h0;
    int o0;

    vecs[0] = '{5'b11111, pack5(50, 40, 30, 20, 10), 150, 5, 30, 0, 22};
    vecs[1] = '{5'b00101, pack5(0, 0, 254, 0, 255), 509, 2, 254, 0, 22};
    vecs[2] = '{5'b00000, pack5(9, 9, 9, 9, 9), 0, 0, 0, 1, 6};
    vecs[3] = '{5'b11111, pack5(255, 255, 255, 255, 255), 1275, 5, 255, 0, 22};
    vecs[4] = '{5'b10010, pack5(100, 0, 0, 7, 0), 107, 2, 53, 0, 22};
    vecs[5] = '{5'b01000, pack5(0, 1, 0, 0, 0), 1, 1, 1, 0, 22};
    vecs[6] = '{5'b11110, pack5(6, 5, 4, 3, 200), 18, 4, 4, 0, 22};

    rst_n         = 1'b0;
    start         = 1'b0;
    auto_en       = 1'b0;
    en            = '0;
    data          = '0;
    rif.avg_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_res("reset", 0, 0, 0, 0);
    chk("reset valid", int'(rif.avg_valid), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset overrun", int'(ovr), 0);
    rst_n = 1'b1;
    step();

    rif.avg_ready = 1'b1;
    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Held result under backpressure, trigger queued during OUT.
    o0            = ovr_cnt;
    rif.avg_ready = 1'b0;
    en            = 5'b11111;
    data          = pack5(1, 2, 3, 4, 5);
    start         = 1'b1;
    step();
    start = 1'b0;
    wait_valid(lat);
    chk("hold latency", lat, 22);
    s0 = int'(rif.temp_sum);
    chk("hold sum", s0, 15);
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      step();
      chk($sformatf("hold valid %0d", i), int'(rif.avg_valid), 1);
      chk($sformatf("hold sum %0d", i), int'(rif.temp_sum), 15);
    end
    start         = 1'b0;
    data          = pack5(100, 0, 0, 0, 0);
    rif.avg_ready = 1'b1;
    step();
    chk("hold drop", int'(rif.avg_valid), 0);
    chk("hold idle", int'(busy), 0);
    step();
    chk("pending capture", int'(busy), 1);
    data = pack5(7, 7, 7, 7, 7);
    wait_valid(lat);
    chk("pending latency", lat, 22);
    chk_res("pending", 100, 5, 20, 0);
    chk("hold overrun", ovr_cnt - o0, 0);
    step();

    // Periodic triggers with the consumer stalled.
    rif.avg_ready = 1'b0;
    en            = 5'b11111;
    data          = pack5(1, 2, 3, 4, 5);
    h0            = hs_cnt;
    o0            = ovr_cnt;
    auto_en       = 1'b1;
    lat           = 0;
    while (ovr_cnt == o0 && lat < 200) begin
      step();
      lat++;
    end
    auto_en = 1'b0;
    chk("auto overrun edge", lat, 61);
    chk("auto no handshake", hs_cnt - h0, 0);
    repeat (5) step();
    chk("auto overrun once", ovr_cnt - o0, 1);
    rif.avg_ready = 1'b1;
    repeat (80) step();
    chk("auto scans", hs_cnt - h0, 2);
    chk("auto overrun total", ovr_cnt - o0, 1);
    chk("auto idle", int'(busy), 0);
    chk("auto sum", int'(rif.temp_sum), 15);

    // Asynchronous reset in the middle of a division.
    en    = 5'b11111;
    data  = pack5(50, 40, 30, 20, 10);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    chk("pre-reset busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_res("async reset", 0, 0, 0, 0);
    chk("async reset valid", int'(rif.avg_valid), 0);
    chk("async reset busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_vec(vecs[4], "post-reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
